fetch_queue_unit: RTL and testbench

Parametrised successor to the single-register fetch stage. Holds the fetch PC, issues sequential requests to the instruction cache using the iREN/ihit handshake, and buffers fetched {pc, instr} pairs in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake. Redirects (branch, jump, jump-register) come from a later pipeline stage, compute the target internally, and flush the queue and any in-flight request.

---
 rtl/cpu_types_pkg.sv | 58 +++++
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_queue_unit.sv | 107 ++++++++++
 tb/tb_fetch_queue_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the fetch path. Defines the machine word,
//               the redirect-source encoding, the queued {pc, instr} entry,
//               and helpers that decode a redirect and compute its target.
// Ports       : none (package)
// Revision    : 1.0 - initial parametrised fetch queue release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Any value other than SEQ that is one of the defined encodings redirects
  // fetch. Undefined encodings (000, 101..111) are treated as SEQ.
  typedef enum logic [2:0] {
    SEQ    = 3'b001,
    BRANCH = 3'b010,
    JUMP   = 3'b011,
    JREG   = 3'b100
  } pcsrc_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t c_pc_step = 32'd4;

  function automatic logic is_redirect(input logic [2:0] src);
    return (src == BRANCH) || (src == JUMP) || (src == JREG);
  endfunction

  // Branch offsets are sign-extended word offsets relative to pc+4. Jumps
  // keep the top nibble of pc+4 (the delay-slot region), not of pc itself.
  function automatic word_t calc_target(
    input logic [2:0]  src,
    input word_t       pc,
    input logic [15:0] imm,
    input logic [25:0] jaddr,
    input word_t       reg_target
  );
    word_t pc4;
    word_t t;
    pc4 = pc + c_pc_step;
    case (src)
      BRANCH:  t = pc4 + {{14{imm[15]}}, imm, 2'b00};
      JUMP:    t = {pc4[31:28], jaddr, 2'b00};
      JREG:    t = reg_target;
      default: t = pc4;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO with flush. Head data is read
//               combinationally from the read-pointer entry; there is no
//               write-to-read bypass, so a pushed entry is visible one cycle
//               later. Flush has priority over push and pop.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               push, din    - write request and data (ignored when full)
//               pop          - read request (ignored when empty)
//               flush        - empty the FIFO on the next edge
//               dout         - head entry
//               full, empty  - status flags
//               count        - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  input  logic                   flush,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                  c_ptr_w      = $clog2(DEPTH);
  localparam logic [c_ptr_w-1:0]  c_ptr_one    = 1;
  localparam logic [c_ptr_w:0]    c_cnt_one    = 1;
  localparam logic [c_ptr_w:0]    c_full_count = DEPTH[c_ptr_w:0];

  T                   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == c_full_count);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module      : fetch_queue_unit
// Description : Fetch stage with a DEPTH-entry instruction queue. Holds the
//               fetch PC, requests sequential words from the I-cache with
//               iREN/ihit, queues {pc, instr} pairs, and presents the head to
//               decode with a valid/ready handshake. A redirect from a later
//               stage computes its target here and flushes the queue and any
//               in-flight request.
// Ports       : CLK, RST              - clock, asynchronous active-high reset
//               iREN, imemaddr        - cache request enable and address
//               ihit, imemload        - cache response
//               fetch_hold            - freeze new requests (queue drains)
//               redir_src, redir_pc,
//               imm16, jaddr,
//               reg_target            - redirect request and target operands
//               out_valid, out_ready,
//               out_instr, out_pc,
//               out_npc               - decode-side head handshake and data
//               q_count               - queue occupancy
// Revision    : 1.0 - initial release (sign-extended branch offsets)
// ============================================================================
`default_nettype none

module fetch_queue_unit
  import cpu_types_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WORD_W   = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   iREN,
  output logic [WORD_W-1:0]      imemaddr,
  input  logic                   ihit,
  input  logic [WORD_W-1:0]      imemload,
  input  logic                   fetch_hold,
  input  logic [2:0]             redir_src,
  input  logic [WORD_W-1:0]      redir_pc,
  input  logic [15:0]            imm16,
  input  logic [25:0]            jaddr,
  input  logic [WORD_W-1:0]      reg_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_instr,
  output logic [WORD_W-1:0]      out_pc,
  output logic [WORD_W-1:0]      out_npc,
  output logic [$clog2(DEPTH):0] q_count
);

  word_t        r_fpc;
  logic         w_redirect;
  word_t        w_target;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_din;
  fetch_entry_t w_head;

  assign w_redirect = is_redirect(redir_src);
  assign w_target   = calc_target(redir_src, redir_pc, imm16, jaddr, reg_target);

  // The full flag is used as-is: a same-cycle pop does not open a slot for a
  // push, which keeps out_ready off the iREN timing path. RST gates the
  // request directly so it drops without waiting for a clock edge.
  assign iREN     = !RST && !w_redirect && !fetch_hold && !w_full;
  assign imemaddr = r_fpc;

  assign w_push   = iREN && ihit;
  assign w_pop    = out_valid && out_ready;
  assign w_din    = '{pc: r_fpc, instr: imemload};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fpc <= RESET_PC;
    end else if (w_redirect) begin
      r_fpc <= w_target;
    end else if (w_push) begin
      r_fpc <= r_fpc + c_pc_step;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .flush (w_redirect),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (q_count)
  );

  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign out_npc   = w_head.pc + c_pc_step;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit. Stimulus pushes the
//               expected {pc, instr} of each accepted fetch into a scoreboard;
//               a monitor pops and compares whenever decode takes the head.
//               Directed checks cover reset, fill, streaming, redirects, hold
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue_unit;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        fetch_hold;
  logic [2:0]  redir_src;
  logic [31:0] redir_pc;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] reg_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic [$clog2(DEPTH):0] q_count;

  fetch_entry_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // Cache model: instruction word is a fixed tag on the low half of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE};
  endfunction

  assign imemload = instr_of(imemaddr);

  fetch_queue_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .WORD_W   (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iREN       (iREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .fetch_hold (fetch_hold),
    .redir_src  (redir_src),
    .redir_pc   (redir_pc),
    .imm16      (imm16),
    .jaddr      (jaddr),
    .reg_target (reg_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_npc    (out_npc),
    .q_count    (q_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: instr_of(pc)});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Monitor: every accepted head must match the oldest outstanding fetch.
  always @(negedge CLK) begin
    if (RST === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no entry", out_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        check("sb_pc",    out_pc,    e.pc);
        check("sb_instr", out_instr, e.instr);
        check("sb_npc",   out_npc,   e.pc + 32'd4);
      end
    end
  end

  initial begin
    RST        = 1'b1;
    ihit       = 1'b0;
    fetch_hold = 1'b0;
    redir_src  = SEQ;
    redir_pc   = '0;
    imm16      = '0;
    jaddr      = '0;
    reg_target = '0;
    out_ready  = 1'b0;

    // Reset state
    repeat (2) sample();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_iren",  32'(iREN),      32'd0);
    check("rst_count", 32'(q_count),   32'd0);
    check("rst_addr",  imemaddr,       32'h0000_0000);

    // 1. Fill with decode stalled
    @(posedge CLK); #1;
    RST  = 1'b0;
    ihit = 1'b1;
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8); expect_fetch(32'hC);
    repeat (4) step();
    sample();
    check("fill_iren",  32'(iREN),      32'd0);
    check("fill_count", 32'(q_count),   32'd4);
    check("fill_addr",  imemaddr,       32'h0000_0010);
    check("fill_pc",    out_pc,         32'h0000_0000);
    check("fill_valid", 32'(out_valid), 32'd1);
    // ihit while iREN=0 is ignored
    step();
    sample();
    check("full_ihit_count", 32'(q_count), 32'd4);
    check("full_ihit_addr",  imemaddr,     32'h0000_0010);

    // Drain the four entries
    step();
    ihit      = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    sample();
    check("drain_count", 32'(q_count),   32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_sb",    32'(exp_q.size()), 32'd0);

    // 2. Streaming: one push and one pop per cycle
    step();
    ihit = 1'b1;
    for (int k = 0; k < 8; k++) expect_fetch(32'h10 + 32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      sample();
      check("stream_iren", 32'(iREN), 32'd1);
      if (k > 0) begin
        check("stream_count", 32'(q_count), 32'd1);
        check("stream_pc",    out_pc,       32'h10 + 32'(4 * (k - 1)));
      end
      step();
    end
    ihit = 1'b0;
    step();
    sample();
    check("stream_end_count", 32'(q_count), 32'd0);
    check("stream_end_sb",    32'(exp_q.size()), 32'd0);

    // 3. BRANCH with three entries queued: 0x100 + 4 - 8 = 0xFC
    step();
    ihit      = 1'b1;
    out_ready = 1'b0;
    expect_fetch(32'h30); expect_fetch(32'h34); expect_fetch(32'h38);
    repeat (3) step();
    redir_src = BRANCH;
    redir_pc  = 32'h0000_0100;
    imm16     = 16'hFFFE;
    sample();
    check("br_pre_count", 32'(q_count), 32'd3);
    check("br_iren",      32'(iREN),    32'd0);
    step();
    redir_src = SEQ;
    ihit      = 1'b0;
    exp_q.delete();
    sample();
    check("br_count", 32'(q_count),   32'd0);
    check("br_valid", 32'(out_valid), 32'd0);
    check("br_addr",  imemaddr,       32'h0000_00FC);

    // 4. JUMP in the same cycle as ihit and out_ready
    step();
    ihit = 1'b1;
    expect_fetch(32'hFC);
    step();
    redir_src = JUMP;
    redir_pc  = 32'hF000_0000;
    jaddr     = 26'h000_0040;
    out_ready = 1'b1;
    sample();
    check("jmp_iren", 32'(iREN), 32'd0);
    step();
    redir_src = SEQ;
    ihit      = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    sample();
    check("jmp_addr",  imemaddr,       32'hF000_0100);
    check("jmp_count", 32'(q_count),   32'd0);
    check("jmp_valid", 32'(out_valid), 32'd0);

    // 5. JREG while fetch_hold is asserted
    step();
    redir_src  = JREG;
    reg_target = 32'h0040_0020;
    fetch_hold = 1'b1;
    sample();
    check("jr_iren", 32'(iREN), 32'd0);
    step();
    redir_src = SEQ;
    sample();
    check("jr_hold_iren", 32'(iREN),    32'd0);
    check("jr_addr",      imemaddr,     32'h0040_0020);
    check("jr_count",     32'(q_count), 32'd0);
    step();
    sample();
    check("jr_hold2_iren", 32'(iREN), 32'd0);
    step();
    fetch_hold = 1'b0;
    ihit       = 1'b1;
    expect_fetch(32'h0040_0020); expect_fetch(32'h0040_0024);
    sample();
    check("jr_req_iren", 32'(iREN), 32'd1);
    check("jr_req_addr", imemaddr,  32'h0040_0020);
    step();
    sample();
    check("jr_req2_addr", imemaddr, 32'h0040_0024);
    step();
    ihit = 1'b0;
    sample();
    check("jr_q_count", 32'(q_count),   32'd2);
    check("jr_q_valid", 32'(out_valid), 32'd1);
    check("jr_q_pc",    out_pc,         32'h0040_0020);
    check("pre_rst_iren", 32'(iREN),    32'd1);

    // 6. Asynchronous reset between clock edges
    #2;
    RST = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_iren",  32'(iREN),      32'd0);
    check("arst_addr",  imemaddr,       32'h0000_0000);
    check("arst_count", 32'(q_count),   32'd0);
    exp_q.delete();
    step();
    RST = 1'b0;
    sample();
    check("post_rst_iren",  32'(iREN),      32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_addr",  imemaddr,       32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
